// File: rtl/rv_pkg.sv
// Shared RISC-V definitions used by the front end: opcodes, the nop encoding and the fetch entry type.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head word is visible on rdata without a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= next_ptr(wptr);
            if (do_pop)  rptr <= next_ptr(rptr);
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: credit-limited word requests, pc tagging of responses, in-order
// queue toward decode, and redirect handling that discards every stale in-flight response.
module inst_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready
);

    localparam int unsigned QCW = $clog2(DEPTH+1);
    localparam int unsigned OCW = $clog2(MAX_OUT+1);

    logic [XLEN-1:0] fetch_pc;
    logic [OCW-1:0]  outstanding;
    logic [OCW-1:0]  drop_cnt;

    logic [QCW-1:0]  q_count;
    logic            q_empty;
    logic            q_full;
    fetch_entry_t    q_head;
    fetch_entry_t    q_wdata;

    logic [XLEN-1:0] tag_head;
    logic [OCW-1:0]  tag_count;
    logic            tag_full;
    logic            tag_empty;

    logic            grant;
    logic            rsp;
    logic            keep;
    logic            q_pop;
    logic [31:0]     in_use;

    // Reserving a queue slot per outstanding request means no response ever lacks space.
    assign in_use    = 32'(q_count) + 32'(outstanding);
    assign imem_req  = !rst && !redirect && (in_use < DEPTH) && (32'(outstanding) < MAX_OUT);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    assign rsp       = imem_rvalid && (outstanding != '0);
    assign keep      = rsp && (drop_cnt == '0) && !redirect && !rst;
    assign q_pop     = if_valid && id_ready && !redirect;
    assign q_wdata   = '{pc: tag_head, inst: imem_rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + OCW'(grant) - OCW'(rsp);
            // Everything still in flight at a redirect is stale, including earlier drops.
            if (redirect) begin
                drop_cnt <= outstanding - OCW'(rsp);
            end else if (rsp && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - OCW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .pop   (q_pop),
        .flush (redirect),
        .wdata (q_wdata),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (keep),
        .flush (redirect),
        .wdata (imem_addr),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    assign if_valid = !q_empty;
    assign if_inst  = q_empty ? INST_NOP : q_head.inst;
    assign if_pc    = q_empty ? '0 : q_head.pc;

    logic unused_ok;
    assign unused_ok = ^{redirect_pc[1:0], tag_full, tag_empty, tag_count};

    assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding != '0));
    assert property (@(posedge clk) disable iff (rst) (q_full && keep) |-> q_pop);
    assert property (@(posedge clk) disable iff (rst) imem_addr[1:0] == 2'b00);
    assert property (@(posedge clk) disable iff (rst)
        (imem_req && !imem_gnt) |=> (redirect || (imem_req && $stable(imem_addr))));

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: behavioural memory/queue model plus a decoupled pop monitor.
module tb_inst_fetch;
    import rv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    pend_t        pending[$];
    fetch_entry_t exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           q_occ = 0;
    int           last_due = 0;
    int           dut_grants = 0;
    int           first_req_cyc = -1;
    int           first_valid_cyc = -1;
    logic [31:0]  model_pc = RESET_PC;
    logic         obs_req;
    logic         obs_valid;
    logic [31:0]  obs_addr;
    logic [31:0]  obs_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare cycle-level outputs, advance the model.
    task automatic cycle(input bit r, input bit rd, input logic [31:0] rpc, input bit g,
                         input bit ready, input int lat);
        bit    resp;
        bit    exp_req;
        bit    pop;
        bit    kept;
        int    due;
        pend_t head;
        @(negedge clk);
        cyc++;
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = g;
        id_ready    = ready;
        resp        = !r && (pending.size() > 0) && (pending[0].due <= cyc);
        imem_rvalid = resp;
        imem_rdata  = resp ? mem_word(pending[0].addr) : $urandom;
        #1;
        obs_req   = imem_req;
        obs_valid = if_valid;
        obs_addr  = imem_addr;
        obs_pc    = if_pc;
        if (imem_req && imem_gnt) dut_grants++;
        if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
        if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        exp_req = !r && !rd && (q_occ + pending.size() < DEPTH) && (pending.size() < MAX_OUT);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, model_pc);
        check("if_valid", 32'(if_valid), 32'(q_occ != 0));
        if (q_occ == 0) begin
            check("if_inst_empty", if_inst, INST_NOP);
            check("if_pc_empty", if_pc, 32'h0);
        end

        pop  = (q_occ != 0) && ready && !rd && !r;
        kept = 1'b0;
        if (resp) begin
            head = pending.pop_front();
            kept = !head.stale && !rd;
        end
        if (exp_req && g) begin
            exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc)});
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pending.push_back('{addr: model_pc, due: due, stale: 1'b0});
            model_pc = model_pc + 32'd4;
        end
        if (r) begin
            model_pc = RESET_PC;
            pending.delete();
            exp_q.delete();
            q_occ    = 0;
            last_due = 0;
        end else if (rd) begin
            model_pc = {rpc[31:2], 2'b00};
            foreach (pending[i]) pending[i].stale = 1'b1;
            exp_q.delete();
            q_occ = 0;
        end else begin
            q_occ = q_occ + int'(kept) - int'(pop);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || pending.size() != 0); i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        end
        check("drain", exp_q.size() + pending.size(), 32'h0);
    endtask

    // Monitor: every handshake toward decode must match the oldest expected entry.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !redirect && if_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pc %h, expected no entry", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", if_pc, e.pc);
                    check("pop_inst", if_inst, e.inst);
                end
            end
        end
    end

    initial begin
        bit done;
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1);

        // Streaming with 1-cycle memory.
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        repeat (20) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        check("first_valid_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);
        drain();

        // Decode stalled: credit limits fetch to DEPTH requests.
        dut_grants = 0;
        repeat (12) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
        check("stall_grants", 32'(dut_grants), 32'(DEPTH));
        check("stall_req_low", 32'(obs_req), 32'h0);
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        check("fetch_resumes", 32'(dut_grants > DEPTH), 32'h1);
        drain();

        // Three in flight at 3-cycle latency, then redirect to 0x100.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 3);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (obs_valid) break;
        end
        check("redirect_target", obs_pc, 32'h100);
        drain();

        // Redirect coinciding with a response.
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (pending.size() > 0 && pending[0].due <= cyc + 1) begin
                cycle(1'b0, 1'b1, 32'h203, 1'b1, 1'b1, 1);
                check("redirect_cycle_req", 32'(obs_req), 32'h0);
                done = 1'b1;
            end else begin
                cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
            end
        end
        check("redirect_hit_rvalid", 32'(done), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        check("redirect_aligned_addr", obs_addr, 32'h200);
        drain();

        // Grant stall at 0x40.
        cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1);
        repeat (5) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
            check("gnt_stall_addr", obs_addr, 32'h40);
        end
        check("gnt_stall_empty", 32'(obs_valid), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
            if (obs_valid) break;
        end
        check("gnt_stall_pc", obs_pc, 32'h40);
        drain();

        // Reset with queued entries and responses in flight.
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 3);
        check("rst_req_low", 32'(obs_req), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("rst_valid_low", 32'(obs_valid), 32'h0);
        check("rst_addr", obs_addr, RESET_PC);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (obs_valid) break;
        end
        check("rst_first_pc", obs_pc, RESET_PC);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(1, 4)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
